// File: rtl/battleship_game_ctrl.sv
// battleship_game_ctrl
// Turn/game sequencer and shot-legality checker for player A's board in a
// two-board Battleship design. It also drives player A's 4-digit seven-segment
// status display and a 3-bit status word for player B's board.
//
// Ports:
//   clk            system clock, rising edge
//   clr_n          synchronous active-low reset
//   btn1           both players have confirmed ship placement
//   btn2a, btn2b   fire buttons for player A / player B
//   liv_a, liv_b   1 = that player still has ships afloat
//   ok_b           player A's pending attack is legal (from B's board)
//   prev_b, new_b  player B's accepted and proposed attack maps
//   ok_a           player B's proposed attack is legal
//   st             ship-register mux select (0 = initial ships, 1 = survivors)
//   ldr1a, ldr2a   load strobes for player A's ship / attack registers
//   ldr1b, ldr2b   load strobes for player B's ship / attack registers
//   disp_a, disp_b status word codes for A and B
//   seg            active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//   an             active-low digit enables, an[0] = rightmost digit
//
// States:
//   state    | meaning
//   ---------+------------------------------------------------
//   S_LOAD   | waiting for both players to place their ships
//   S_SHIPS  | load both ship registers with the initial layout
//   S_A_TURN | A may fire once B's board reports a legal shot
//   S_A_FIRE | latch A's attack into A's attack register
//   S_A_UPD  | reload B's ship register with the survivors
//   S_A_CHK  | B out of ships -> A wins, else hand over to B
//   S_B_TURN | B may fire once the local checker accepts the shot
//   S_B_FIRE | latch B's attack into B's attack register
//   S_B_UPD  | reload A's ship register with the survivors
//   S_B_CHK  | A out of ships -> B wins, else hand over to A
//   S_A_WIN  | A won, held until reset
//   S_B_WIN  | B won, held until reset

module battleship_game_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        btn1,
    input  logic        btn2a,
    input  logic        btn2b,
    input  logic        liv_a,
    input  logic        liv_b,
    input  logic        ok_b,
    input  logic [15:0] prev_b,
    input  logic [15:0] new_b,
    output logic        ok_a,
    output logic        st,
    output logic        ldr1a,
    output logic        ldr2a,
    output logic        ldr1b,
    output logic        ldr2b,
    output logic [2:0]  disp_a,
    output logic [2:0]  disp_b,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [3:0] {
        S_LOAD, S_SHIPS,
        S_A_TURN, S_A_FIRE, S_A_UPD, S_A_CHK,
        S_B_TURN, S_B_FIRE, S_B_UPD, S_B_CHK,
        S_A_WIN, S_B_WIN
    } state_t;

    typedef struct packed {
        logic       st;
        logic       ldr1a;
        logic       ldr2a;
        logic       ldr1b;
        logic       ldr2b;
        logic [2:0] disp_a;
        logic [2:0] disp_b;
    } outs_t;

    localparam logic [2:0] W_LOAD = 3'd0;
    localparam logic [2:0] W_FIRE = 3'd1;
    localparam logic [2:0] W_HOLD = 3'd2;
    localparam logic [2:0] W_GOOD = 3'd3;
    localparam logic [2:0] W_LOSE = 3'd4;

    localparam logic [7:0] G_L    = 8'hC7;
    localparam logic [7:0] G_O    = 8'hC0;
    localparam logic [7:0] G_A    = 8'h88;
    localparam logic [7:0] G_D    = 8'hA1;
    localparam logic [7:0] G_F    = 8'h8E;
    localparam logic [7:0] G_R    = 8'hAF;
    localparam logic [7:0] G_E    = 8'h86;
    localparam logic [7:0] G_H    = 8'h89;
    localparam logic [7:0] G_G    = 8'hC2;
    localparam logic [7:0] G_S    = 8'h92;
    localparam logic [7:0] G_DASH = 8'hBF;
    localparam logic [7:0] G_I    = 8'hF9;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_TC = CW'(REFRESH_DIV - 1);

    state_t         state;
    outs_t          outs_q;
    logic [15:0]    diff;
    logic [CW-1:0]  div_cnt;
    logic [1:0]     digit;
    logic [31:0]    word_glyphs;

    // Shot legality: no previously attacked cell may be cleared and exactly
    // one new cell must be added.
    assign diff = prev_b ^ new_b;
    assign ok_a = ((prev_b & ~new_b) == 16'd0) && (diff != 16'd0)
                  && ((diff & (diff - 16'd1)) == 16'd0);

    function automatic state_t next_state(
        input state_t s,
        input logic   b1,
        input logic   fire_a,
        input logic   fire_b,
        input logic   alive_a,
        input logic   alive_b,
        input logic   legal_a,
        input logic   legal_b
    );
        state_t nxt;
        nxt = s;
        case (s)
            S_LOAD:   if (b1) nxt = S_SHIPS;
            S_SHIPS:  nxt = S_A_TURN;
            S_A_TURN: if (fire_a && legal_b) nxt = S_A_FIRE;
            S_A_FIRE: nxt = S_A_UPD;
            S_A_UPD:  nxt = S_A_CHK;
            S_A_CHK:  nxt = alive_b ? S_B_TURN : S_A_WIN;
            S_B_TURN: if (fire_b && legal_a) nxt = S_B_FIRE;
            S_B_FIRE: nxt = S_B_UPD;
            S_B_UPD:  nxt = S_B_CHK;
            S_B_CHK:  nxt = alive_a ? S_A_TURN : S_B_WIN;
            S_A_WIN:  nxt = S_A_WIN;
            S_B_WIN:  nxt = S_B_WIN;
            default:  nxt = S_LOAD;
        endcase
        return nxt;
    endfunction

    function automatic outs_t decode(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_LOAD, S_SHIPS: begin
                o.ldr1a = (s == S_SHIPS);
                o.ldr1b = (s == S_SHIPS);
            end
            S_A_TURN, S_A_FIRE, S_A_UPD, S_A_CHK: begin
                o.st     = 1'b1;
                o.ldr2a  = (s == S_A_FIRE);
                o.ldr1b  = (s == S_A_UPD);
                o.disp_a = W_FIRE;
                o.disp_b = W_HOLD;
            end
            S_B_TURN, S_B_FIRE, S_B_UPD, S_B_CHK: begin
                o.st     = 1'b1;
                o.ldr2b  = (s == S_B_FIRE);
                o.ldr1a  = (s == S_B_UPD);
                o.disp_a = W_HOLD;
                o.disp_b = W_FIRE;
            end
            S_A_WIN: begin
                o.st     = 1'b1;
                o.disp_a = W_GOOD;
                o.disp_b = W_LOSE;
            end
            S_B_WIN: begin
                o.st     = 1'b1;
                o.disp_a = W_LOSE;
                o.disp_b = W_GOOD;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Outputs are registered from the decode of the state being entered, so
    // they change on the same edge as the state and stay glitch-free.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= S_LOAD;
            outs_q <= decode(S_LOAD);
        end else begin
            state  <= next_state(state, btn1, btn2a, btn2b, liv_a, liv_b, ok_a, ok_b);
            outs_q <= decode(next_state(state, btn1, btn2a, btn2b, liv_a, liv_b, ok_a, ok_b));
        end
    end

    assign st     = outs_q.st;
    assign ldr1a  = outs_q.ldr1a;
    assign ldr2a  = outs_q.ldr2a;
    assign ldr1b  = outs_q.ldr1b;
    assign ldr2b  = outs_q.ldr2b;
    assign disp_a = outs_q.disp_a;
    assign disp_b = outs_q.disp_b;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            div_cnt <= '0;
            digit   <= 2'd0;
        end else if (div_cnt == DIV_TC) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign an = ~(4'b0001 << digit);

    // Leftmost character in the top byte so digit index 3 shows it.
    always_comb begin
        word_glyphs = {G_DASH, G_DASH, G_DASH, G_DASH};
        case (disp_a)
            W_LOAD:  word_glyphs = {G_L, G_O, G_A, G_D};
            W_FIRE:  word_glyphs = {G_F, G_I, G_R, G_E};
            W_HOLD:  word_glyphs = {G_H, G_O, G_L, G_D};
            W_GOOD:  word_glyphs = {G_G, G_O, G_O, G_D};
            W_LOSE:  word_glyphs = {G_L, G_O, G_S, G_E};
            default: word_glyphs = {G_DASH, G_DASH, G_DASH, G_DASH};
        endcase
    end

    always_comb begin
        seg = word_glyphs[7:0];
        case (digit)
            2'd0: seg = word_glyphs[7:0];
            2'd1: seg = word_glyphs[15:8];
            2'd2: seg = word_glyphs[23:16];
            2'd3: seg = word_glyphs[31:24];
        endcase
    end

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Self-checking bench for battleship_game_ctrl. Random games are played against
// a game-level reference model; load strobes are checked through a scoreboard
// queue, while status words, mux select and the display scan are checked every
// cycle against the model's expectations.

module tb_battleship_game_ctrl;

    localparam int RDIV = 2;

    logic        clk = 1'b0;
    logic        clr_n, btn1, btn2a, btn2b, liv_a, liv_b, ok_b;
    logic [15:0] prev_b, new_b;
    logic        ok_a, st, ldr1a, ldr2a, ldr1b, ldr2b;
    logic [2:0]  disp_a, disp_b;
    logic [7:0]  seg;
    logic [3:0]  an;

    battleship_game_ctrl #(.REFRESH_DIV(RDIV)) dut (
        .clk(clk), .clr_n(clr_n), .btn1(btn1), .btn2a(btn2a), .btn2b(btn2b),
        .liv_a(liv_a), .liv_b(liv_b), .ok_b(ok_b), .prev_b(prev_b), .new_b(new_b),
        .ok_a(ok_a), .st(st), .ldr1a(ldr1a), .ldr2a(ldr2a), .ldr1b(ldr1b),
        .ldr2b(ldr2b), .disp_a(disp_a), .disp_b(disp_b), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected strobe events, packed as {st, ldr1a, ldr2a, ldr1b, ldr2b}.
    logic [4:0] sb_q[$];

    logic [2:0] exp_da = 3'd0;
    logic [2:0] exp_db = 3'd0;
    logic       exp_st = 1'b0;
    bit         armed = 1'b0;
    int         scan_k = 0;

    string words[8] = '{"LOAd", "FIrE", "HOLd", "GOOd", "LOSE", "----", "----", "----"};

    function automatic logic [7:0] font(input byte c);
        case (c)
            "L": return 8'hC7;
            "O": return 8'hC0;
            "A": return 8'h88;
            "d": return 8'hA1;
            "F": return 8'h8E;
            "r": return 8'hAF;
            "E": return 8'h86;
            "H": return 8'h89;
            "G": return 8'hC2;
            "S": return 8'h92;
            "-": return 8'hBF;
            "I": return 8'hF9;
            default: return 8'h00;
        endcase
    endfunction

    // A legal shot keeps every earlier hit and adds exactly one new cell.
    function automatic logic legal_model(input logic [15:0] p, input logic [15:0] n);
        int added = 0;
        bit lost = 0;
        for (int i = 0; i < 16; i++) begin
            if (p[i] && !n[i]) lost = 1;
            if (!p[i] && n[i]) added++;
        end
        return (!lost && added == 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input logic [2:0] da, input logic [2:0] db, input logic s);
        exp_da = da;
        exp_db = db;
        exp_st = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic legal_maps();
        int j;
        j = $urandom_range(0, 15);
        prev_b = 16'($urandom) & ~(16'd1 << j);
        new_b  = prev_b | (16'd1 << j);
    endtask

    task automatic illegal_maps();
        int j, k, kind;
        j = $urandom_range(0, 15);
        k = (j + $urandom_range(1, 15)) % 16;
        kind = $urandom_range(0, 2);
        prev_b = 16'($urandom);
        if (kind == 0) begin
            new_b = prev_b;
        end else if (kind == 1) begin
            prev_b = prev_b | (16'd1 << j);
            new_b  = prev_b & ~(16'd1 << j);
        end else begin
            prev_b = prev_b & ~(16'd1 << j) & ~(16'd1 << k);
            new_b  = prev_b | (16'd1 << j) | (16'd1 << k);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        int         idx;
        logic [3:0] exp_an;
        logic [4:0] ev;
        string      w;
        forever begin
            @(posedge clk);
            #1;
            if (clr_n === 1'b0) begin
                armed  = 1'b1;
                scan_k = 0;
            end else if (armed) begin
                scan_k++;
            end
            if (armed) begin
                idx    = (scan_k / RDIV) % 4;
                exp_an = ~(4'b0001 << idx);
                w      = words[exp_da];
                check("an", 32'(an), 32'(exp_an));
                check("seg", 32'(seg), 32'(font(w[3 - idx])));
                check("disp_a", 32'(disp_a), 32'(exp_da));
                check("disp_b", 32'(disp_b), 32'(exp_db));
                check("st", 32'(st), 32'(exp_st));
                ev = {st, ldr1a, ldr2a, ldr1b, ldr2b};
                if (ev[3:0] != 4'd0) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe: got %b expected none at %0t", ev, $time);
                    end else begin
                        check("strobe", 32'(ev), 32'(sb_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int  rounds;
        bit  over, a_wins, b_wins;
        clr_n = 1'b1; btn1 = 1'b0; btn2a = 1'b0; btn2b = 1'b0;
        liv_a = 1'b1; liv_b = 1'b1; ok_b = 1'b0;
        prev_b = 16'd0; new_b = 16'd0;
        @(negedge clk);

        // Directed checker corners.
        prev_b = 16'h0001; new_b = 16'h0003; #1 check("ok_a add one", 32'(ok_a), 32'd1);
        new_b = 16'h0007; #1 check("ok_a add two", 32'(ok_a), 32'd0);
        new_b = 16'h0002; #1 check("ok_a drop bit", 32'(ok_a), 32'd0);
        new_b = 16'h0001; #1 check("ok_a identical", 32'(ok_a), 32'd0);
        repeat (30) begin
            if ($urandom_range(0, 1) == 1) legal_maps();
            else illegal_maps();
            #1 check("ok_a random", 32'(ok_a), 32'(legal_model(prev_b, new_b)));
        end
        @(negedge clk);

        for (int g = 0; g < 3; g++) begin
            clr_n = 1'b0;
            cyc(3'd0, 3'd0, 1'b0);
            clr_n = 1'b1;
            repeat (g == 0 ? 9 : $urandom_range(1, 4)) begin
                btn2a = 1'($urandom); btn2b = 1'($urandom);
                cyc(3'd0, 3'd0, 1'b0);
            end
            btn1 = 1'b1; btn2a = 1'b0; btn2b = 1'b0;
            sb_q.push_back(5'b01010);
            cyc(3'd0, 3'd0, 1'b0);
            btn1 = 1'b0;
            cyc(3'd1, 3'd2, 1'b1);

            rounds = $urandom_range(1, 3);
            over = 1'b0;
            for (int r = 0; r < rounds && !over; r++) begin
                // A's turn: presses without a legal shot must not fire.
                repeat ($urandom_range(0, 3)) begin
                    if ($urandom_range(0, 1) == 1) begin btn2a = 1'b1; ok_b = 1'b0; end
                    else begin btn2a = 1'b0; ok_b = 1'($urandom); end
                    btn2b = 1'($urandom);
                    cyc(3'd1, 3'd2, 1'b1);
                end
                btn2a = 1'b1; ok_b = 1'b1; btn2b = 1'b0;
                sb_q.push_back(5'b10100);
                if (g == 2 && r == rounds - 1) begin
                    cyc(3'd1, 3'd2, 1'b1);
                    btn2a = 1'b0;
                    clr_n = 1'b0;
                    cyc(3'd0, 3'd0, 1'b0);
                    clr_n = 1'b1;
                    repeat (3) cyc(3'd0, 3'd0, 1'b0);
                    over = 1'b1;
                end else begin
                    a_wins = (g == 0 && r == rounds - 1);
                    liv_b = !a_wins;
                    liv_a = 1'($urandom);
                    sb_q.push_back(5'b10010);
                    cyc(3'd1, 3'd2, 1'b1);
                    btn2a = 1'($urandom);
                    cyc(3'd1, 3'd2, 1'b1);
                    cyc(3'd1, 3'd2, 1'b1);
                    if (a_wins) begin
                        cyc(3'd3, 3'd4, 1'b1);
                        repeat (4) begin
                            btn1 = 1'($urandom); btn2a = 1'b1; btn2b = 1'b1; ok_b = 1'b1;
                            legal_maps();
                            cyc(3'd3, 3'd4, 1'b1);
                        end
                        over = 1'b1;
                    end else begin
                        cyc(3'd2, 3'd1, 1'b1);
                    end
                end
                if (!over) begin
                    // B's turn: either the button or the shot legality is missing.
                    repeat ($urandom_range(0, 3)) begin
                        if ($urandom_range(0, 1) == 1) begin
                            btn2b = 1'b1;
                            illegal_maps();
                        end else begin
                            btn2b = 1'b0;
                            if ($urandom_range(0, 1) == 1) legal_maps();
                            else illegal_maps();
                        end
                        btn2a = 1'($urandom); ok_b = 1'($urandom);
                        #1 check("ok_a in turn", 32'(ok_a), 32'(legal_model(prev_b, new_b)));
                        cyc(3'd2, 3'd1, 1'b1);
                    end
                    legal_maps();
                    btn2b = 1'b1; btn2a = 1'b0;
                    #1 check("ok_a fire", 32'(ok_a), 32'(legal_model(prev_b, new_b)));
                    b_wins = (g == 1 && r == rounds - 1);
                    liv_a = !b_wins;
                    liv_b = 1'b1;
                    sb_q.push_back(5'b10001);
                    sb_q.push_back(5'b11000);
                    cyc(3'd2, 3'd1, 1'b1);
                    btn2b = 1'($urandom);
                    cyc(3'd2, 3'd1, 1'b1);
                    cyc(3'd2, 3'd1, 1'b1);
                    if (b_wins) begin
                        cyc(3'd4, 3'd3, 1'b1);
                        repeat (4) begin
                            btn1 = 1'($urandom); btn2a = 1'b1; btn2b = 1'b1; ok_b = 1'b1;
                            legal_maps();
                            cyc(3'd4, 3'd3, 1'b1);
                        end
                        over = 1'b1;
                    end else begin
                        cyc(3'd1, 3'd2, 1'b1);
                    end
                end
            end
            btn1 = 1'b0; btn2a = 1'b0; btn2b = 1'b0; ok_b = 1'b0;
            liv_a = 1'b1; liv_b = 1'b1;
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL strobe queue: %0d events outstanding, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/battleship_game_ctrl.md
Name: battleship_game_ctrl

Overview:
Game controller for one player board (player A) in the two-board Battleship design. It holds the turn/game state machine and an attack-legality checker for the opponent's shots. It also drives a 4-digit multiplexed seven-segment status display for player A and a 3-bit status word for player B's board. The ship, attack and history registers sit outside this block and are driven by its load strobes and mux select.

Parameters:
REFRESH_DIV, 100000, clock cycles each display digit stays lit before the scan advances (minimum 1).

Ports:
clk  in  1  system clock, all state updates on rising edge
clr_n  in  1  synchronous active-low reset
btn1  in  1  both players confirm ship placement (already ANDed externally)
btn2a  in  1  player A fire button
btn2b  in  1  player B fire button
liv_a  in  1  1 = player A still has ships
liv_b  in  1  1 = player B still has ships
ok_b  in  1  player A's pending attack is legal (from B's board)
prev_b  in  16  player B's previously accepted attack map
new_b  in  16  player B's proposed attack map
ok_a  out  1  player B's proposed attack is legal (checker result)
st  out  1  ship-register mux select: 0 = load initial ships, 1 = load survivors
ldr1a  out  1  load player A ship register
ldr2a  out  1  load player A attack register
ldr1b  out  1  load player B ship register
ldr2b  out  1  load player B attack register
disp_a  out  3  player A status word code
disp_b  out  3  player B status word code
seg  out  8  active-low segments, seg[6:0]=g,f,e,d,c,b,a, seg[7]=dp (always 1)
an  out  4  active-low digit enables, an[0]=rightmost

Behaviour:
- Checker (combinational): ok_a=1 iff (prev_b & ~new_b)==0 AND (prev_b ^ new_b) has exactly one bit set. Otherwise 0. Identical maps give 0.
- The FSM is Moore. Outputs decode from state only. Strobes are 1-cycle pulses. Unlisted outputs are 0.
- LOAD: st=0, disp_a=disp_b=0. btn1 -> SHIPS.
- SHIPS: ldr1a=ldr1b=1, st=0. Next state is A_TURN.
- A_TURN: st=1, disp_a=1, disp_b=2. (btn2a & ok_b) -> A_FIRE.
- A_FIRE: ldr2a=1, st=1, same display as A_TURN. Next state is A_UPD.
- A_UPD: ldr1b=1, st=1. Next state is A_CHK.
- A_CHK: st=1. If liv_b==0, go to A_WIN. Otherwise go to B_TURN.
- B_TURN: st=1, disp_a=2, disp_b=1. (btn2b & ok_a) -> B_FIRE.
- B_FIRE: ldr2b=1. Next state is B_UPD.
- B_UPD: ldr1a=1. Next state is B_CHK.
- B_CHK: if liv_a==0, go to B_WIN. Otherwise go to A_TURN.
- A_WIN: disp_a=3, disp_b=4. Terminal until reset.
- B_WIN: disp_a=4, disp_b=3. Terminal until reset.
- A_UPD, A_CHK, B_* and *_WIN states all keep st=1. Displays hold the turn codes through the UPD and CHK states.
- Fire buttons are only sampled in their own TURN state, so a held button cannot fire twice in one turn.
- Word codes: 0="LOAd", 1="FIrE", 2="HOLd", 3="GOOd", 4="LOSE", 5..7="----". The first character goes on the leftmost digit (an[3]).
- Display scan: a divider counts REFRESH_DIV cycles, then the digit index advances 0->1->2->3->0. Index 0 drives an=1110 (rightmost character), index 3 drives an=0111. Exactly one anode is low at all times.
- The display shows the current disp_a combinationally. seg reflects a word change in the same cycle the state changes.
- Segment codes including dp=1: L=C7, O=C0, A=88, d=A1, F=8E, r=AF, E=86, H=89, G=C2, S=92, -=BF, I=F9.
- Reset (clr_n=0 at a clock edge) has priority over all other inputs at any point in the game. It returns state to LOAD, the divider to 0 and the digit index to 0, giving an=1110.

Test Plan:
- Checker: prev=0x0001, new=0x0003 -> ok_a=1. new=0x0007 -> 0. new=0x0002 (bit dropped) -> 0. new=0x0001 -> 0.
- Setup: reset, btn1 pulse -> ldr1a=ldr1b=1 and st=0 for exactly 1 cycle, then A_TURN with disp_a=1, disp_b=2, st=1.
- Full A turn: btn2a=1, ok_b=0 -> stays in A_TURN. Raise ok_b -> ldr2a pulse, ldr1b pulse next cycle. With liv_b=1, reach B_TURN (disp_a=2, disp_b=1).
- Win: in the B turn, btn2b=1 with legal prev_b/new_b, liv_a forced 0 -> ldr2b pulse, ldr1a pulse, then disp_a=4, disp_b=3. Stays there with further button presses.
- Display with REFRESH_DIV=2: after reset in LOAD, an=1110/seg=A1 for 2 cycles, then an=1101/seg=88, then an=1011/seg=C0, then an=0111/seg=C7.
- Mid-game clr_n=0 for one edge during A_FIRE -> next cycle is LOAD with all strobes 0, st=0, an=1110.
